regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: single-issue IDLE/READ/EXEC/WRITE sequencer driving an external 2R1W register file.
// Optional zero/carry flag registers are built only when RFSEQ_FLAGS_EN is defined.
`timescale 1ns/1ps

module regfile_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_dst,
  input  logic [ADDR_WIDTH-1:0] instr_srca,
  input  logic [ADDR_WIDTH-1:0] instr_srcb,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  output logic [ADDR_WIDTH-1:0] RAA,
  output logic [ADDR_WIDTH-1:0] RAB,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] W,
  output logic [ADDR_WIDTH-1:0] WA,
  output logic                  Wen,
  output logic                  done,
  output logic                  flag_z,
  output logic                  flag_c
);

  localparam int unsigned OP_WIDTH = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MOV = 3'b101,
    OP_LDI = 3'b110,
    OP_NOP = 3'b111
  } op_e;

  // Latched instruction fields; source indices live directly in RAA/RAB.
  typedef struct packed {
    op_e                   op;
    logic [ADDR_WIDTH-1:0] dst;
    logic [DATA_WIDTH-1:0] imm;
  } instr_t;

  state_e                state_q;
  state_e                state_d;
  instr_t                instr_q;
  instr_t                instr_d;
  logic                  accept_c;
  logic [DATA_WIDTH-1:0] alu_res_c;
  logic [ADDR_WIDTH-1:0] raa_d;
  logic [ADDR_WIDTH-1:0] rab_d;
  logic [ADDR_WIDTH-1:0] wa_d;
  logic [DATA_WIDTH-1:0] w_d;
  logic                  wen_d;
  logic                  done_d;
  logic                  ready_d;

  assign accept_c = instr_valid & instr_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every state but IDLE lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept_c) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operands come straight from the regfile read ports
  always_comb begin
    alu_res_c = '0;
    unique case (instr_q.op)
      OP_ADD:  alu_res_c = A + B;
      OP_SUB:  alu_res_c = A - B;
      OP_AND:  alu_res_c = A & B;
      OP_OR:   alu_res_c = A | B;
      OP_XOR:  alu_res_c = A ^ B;
      OP_MOV:  alu_res_c = A;
      OP_LDI:  alu_res_c = instr_q.imm;
      OP_NOP:  alu_res_c = '0;
      default: alu_res_c = '0;
    endcase
  end

`ifdef RFSEQ_FLAGS_EN
  logic [DATA_WIDTH:0] sum_ext_c;
  logic                carry_c;
  logic                flag_z_d;
  logic                flag_c_d;

  assign sum_ext_c = {1'b0, A} + {1'b0, B};

  // Carry out of ADD, borrow out of SUB, cleared for all logic/move ops
  always_comb begin
    carry_c = 1'b0;
    if (instr_q.op == OP_ADD) begin
      carry_c = sum_ext_c[DATA_WIDTH];
    end else if (instr_q.op == OP_SUB) begin
      carry_c = (A < B);
    end
  end
`endif

  // Output logic: next values of all registered outputs
  always_comb begin
    instr_d = instr_q;
    raa_d   = RAA;
    rab_d   = RAB;
    w_d     = W;
    wa_d    = WA;
    wen_d   = 1'b0;
    done_d  = 1'b0;
    ready_d = (state_d == S_IDLE);
`ifdef RFSEQ_FLAGS_EN
    flag_z_d = flag_z;
    flag_c_d = flag_c;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          instr_d.op  = op_e'(instr_op);
          instr_d.dst = instr_dst;
          instr_d.imm = instr_imm;
          raa_d       = instr_srca;
          rab_d       = instr_srcb;
        end
      end
      S_EXEC: begin
        // Results land in W/WA at the edge that opens WRITE, so Wen and data align
        done_d = 1'b1;
        if (instr_q.op != OP_NOP) begin
          w_d   = alu_res_c;
          wa_d  = instr_q.dst;
          wen_d = 1'b1;
`ifdef RFSEQ_FLAGS_EN
          flag_z_d = (alu_res_c == '0);
          flag_c_d = carry_c;
`endif
        end
      end
      default: ;
    endcase
  end

  // Output and instruction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q     <= '0;
      instr_ready <= 1'b1;
      RAA         <= '0;
      RAB         <= '0;
      W           <= '0;
      WA          <= '0;
      Wen         <= 1'b0;
      done        <= 1'b0;
    end else begin
      instr_q     <= instr_d;
      instr_ready <= ready_d;
      RAA         <= raa_d;
      RAB         <= rab_d;
      W           <= w_d;
      WA          <= wa_d;
      Wen         <= wen_d;
      done        <= done_d;
    end
  end

`ifdef RFSEQ_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      flag_z <= flag_z_d;
      flag_c <= flag_c_d;
    end
  end
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer with a behavioural 16x8 register file attached.
`timescale 1ns/1ps

module tb_regfile_sequencer;

`ifdef RFSEQ_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  localparam bit [2:0] OP_ADD = 3'd0;
  localparam bit [2:0] OP_SUB = 3'd1;
  localparam bit [2:0] OP_AND = 3'd2;
  localparam bit [2:0] OP_OR  = 3'd3;
  localparam bit [2:0] OP_XOR = 3'd4;
  localparam bit [2:0] OP_MOV = 3'd5;
  localparam bit [2:0] OP_LDI = 3'd6;
  localparam bit [2:0] OP_NOP = 3'd7;

  typedef struct {
    bit       wen;
    bit [3:0] wa;
    bit [7:0] w;
    bit       fz;
    bit       fc;
    int       hs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [3:0] instr_dst;
  logic [3:0] instr_srca;
  logic [3:0] instr_srcb;
  logic [7:0] instr_imm;
  logic [3:0] RAA;
  logic [3:0] RAB;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] W;
  logic [3:0] WA;
  logic       Wen;
  logic       done;
  logic       flag_z;
  logic       flag_c;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wen_cnt = 0;
  logic preload = 1'b1;
  logic [7:0] rf [16];
  logic [7:0] ref_rf [16];
  bit   ref_z;
  bit   ref_c;
  exp_t exp_q [$];
  exp_t mon_e;

  always #5 clk = ~clk;

  regfile_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op   (instr_op),
    .instr_dst  (instr_dst),
    .instr_srca (instr_srca),
    .instr_srcb (instr_srcb),
    .instr_imm  (instr_imm),
    .RAA        (RAA),
    .RAB        (RAB),
    .A          (A),
    .B          (B),
    .W          (W),
    .WA         (WA),
    .Wen        (Wen),
    .done       (done),
    .flag_z     (flag_z),
    .flag_c     (flag_c)
  );

  // Behavioural register file: combinational reads, write on rising edge
  assign A = rf[RAA];
  assign B = rf[RAB];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (Wen) wen_cnt <= wen_cnt + 1;
    if (preload) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'(i * 17);
    end else if (Wen) begin
      rf[WA] <= W;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: predicts the write and updates the shadow register file
  task automatic predict(input bit [2:0] op, input bit [3:0] dst, input bit [3:0] sa,
                         input bit [3:0] sb, input bit [7:0] imm, output exp_t e);
    int a;
    int b;
    int r;
    bit c;
    a = int'(ref_rf[sa]);
    b = int'(ref_rf[sb]);
    c = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; c = (r > 255); end
      OP_SUB: begin r = a - b; c = (a < b); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_MOV: r = a;
      OP_LDI: r = int'(imm);
      default: r = 0;
    endcase
    e.wen = (op != OP_NOP);
    e.wa  = dst;
    e.w   = 8'(r & 255);
    if (op != OP_NOP) begin
      ref_rf[dst] = e.w;
      ref_z = (e.w == 8'h00);
      ref_c = c;
    end
    e.fz = FLAGS_EN & ref_z;
    e.fc = FLAGS_EN & ref_c;
    e.hs = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake edge
  task automatic issue(input bit [2:0] op, input bit [3:0] dst, input bit [3:0] sa,
                       input bit [3:0] sb, input bit [7:0] imm, input bit track, output int hs);
    exp_t e;
    int   budget;
    instr_valid = 1'b1;
    instr_op    = op;
    instr_dst   = dst;
    instr_srca  = sa;
    instr_srcb  = sb;
    instr_imm   = imm;
    budget = 0;
    while (instr_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20) check("ready_timeout", instr_ready, 1'b1);
    hs = cyc + 1;
    if (track) begin
      predict(op, dst, sa, sb, imm, e);
      e.hs = hs;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int b;
    b = 0;
    instr_valid = 1'b0;
    while (exp_q.size() != 0 && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (b >= 50) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compare every completion against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (Wen && !done) check("wen_without_done", Wen, 1'b0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", done, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wen", Wen, mon_e.wen);
          if (mon_e.wen) begin
            check("wa", WA, mon_e.wa);
            check("w", W, mon_e.w);
          end
          check("flag_z", flag_z, mon_e.fz);
          check("flag_c", flag_c, mon_e.fc);
          check("latency", cyc + 1 - mon_e.hs, 3);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int hs1;
    int hs2;
    int rel;
    int wen_before;
    logic [7:0] old2;
    instr_valid = 1'b0;
    instr_op    = 3'd0;
    instr_dst   = 4'd0;
    instr_srca  = 4'd0;
    instr_srcb  = 4'd0;
    instr_imm   = 8'd0;
    for (int i = 0; i < 16; i++) ref_rf[i] = 8'(i * 17);
    ref_z = 1'b0;
    ref_c = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", instr_ready, 1'b1);
    check("rst_wen", Wen, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_raa", RAA, 4'd0);
    check("rst_rab", RAB, 4'd0);
    check("rst_w", W, 8'd0);
    check("rst_wa", WA, 4'd0);
    check("rst_flag_z", flag_z, 1'b0);
    check("rst_flag_c", flag_c, 1'b0);
    repeat (3) @(negedge clk);
    preload = 1'b0;
    rst_n = 1'b1;
    rel = cyc;

    // ADD without carry
    issue(OP_LDI, 4'd1, 4'd0, 4'd0, 8'h05, 1'b1, hs);
    check("first_hs_after_reset", hs, rel + 1);
    issue(OP_LDI, 4'd2, 4'd0, 4'd0, 8'h03, 1'b1, hs);
    issue(OP_ADD, 4'd4, 4'd1, 4'd2, 8'h00, 1'b1, hs);
    // ADD with carry out
    issue(OP_LDI, 4'd1, 4'd0, 4'd0, 8'hF0, 1'b1, hs);
    issue(OP_LDI, 4'd2, 4'd0, 4'd0, 8'h20, 1'b1, hs);
    issue(OP_ADD, 4'd5, 4'd1, 4'd2, 8'h00, 1'b1, hs);
    // SUB with borrow, then SUB to zero
    issue(OP_LDI, 4'd1, 4'd0, 4'd0, 8'h03, 1'b1, hs);
    issue(OP_LDI, 4'd2, 4'd0, 4'd0, 8'h05, 1'b1, hs);
    issue(OP_SUB, 4'd6, 4'd1, 4'd2, 8'h00, 1'b1, hs);
    issue(OP_LDI, 4'd1, 4'd0, 4'd0, 8'h07, 1'b1, hs);
    issue(OP_LDI, 4'd2, 4'd0, 4'd0, 8'h07, 1'b1, hs);
    issue(OP_SUB, 4'd9, 4'd1, 4'd2, 8'h00, 1'b1, hs);
    // LDI then dependent MOV back-to-back
    issue(OP_LDI, 4'd7, 4'd0, 4'd0, 8'hA5, 1'b1, hs1);
    issue(OP_MOV, 4'd8, 4'd7, 4'd0, 8'h00, 1'b1, hs2);
    check("b2b_spacing", hs2 - hs1, 4);
    // NOP and logic ops
    issue(OP_NOP, 4'd3, 4'd1, 4'd2, 8'h00, 1'b1, hs);
    issue(OP_AND, 4'd10, 4'd8, 4'd5, 8'h00, 1'b1, hs);
    issue(OP_OR,  4'd11, 4'd8, 4'd5, 8'h00, 1'b1, hs);
    issue(OP_XOR, 4'd12, 4'd8, 4'd8, 8'h00, 1'b1, hs);
    drain();

    // Random mix with occasional idle gaps
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        instr_valid = 1'b0;
        @(negedge clk);
      end
      issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b1, hs);
    end
    drain();

    // Abort an ADD into r2 while in EXEC
    old2 = ref_rf[2];
    wen_before = wen_cnt;
    issue(OP_ADD, 4'd2, 4'd1, 4'd3, 8'h00, 1'b0, hs);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    #1;
    check("abort_ready", instr_ready, 1'b1);
    check("abort_wen", Wen, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_raa", RAA, 4'd0);
    check("abort_w", W, 8'd0);
    ref_z = 1'b0;
    ref_c = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_write", wen_cnt, wen_before);
    rst_n = 1'b1;
    rel = cyc;
    issue(OP_LDI, 4'd11, 4'd0, 4'd0, 8'h3C, 1'b1, hs);
    check("hs_after_abort", hs, rel + 1);
    drain();
    check("abort_r2_kept", rf[2], old2);

    for (int i = 0; i < 16; i++) check($sformatf("rf_final[%0d]", i), rf[i], ref_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
